traffic_phase_ctrl: RTL

Parametrised multi-phase traffic-light sequencer. It generalises the fixed two-direction controller to NUM_PHASES approach groups, with programmable green/yellow/all-red durations and a built-in seconds prescaler. It also adds pedestrian-request truncation, manual step mode and a night-flash mode. It sits directly under the board top and drives the lamp LEDs and the 2-digit countdown for the nixie-tube scanner.

---
 rtl/tlc_pkg.sv | 32 +++
 rtl/tlc_tick_gen.sv | 36 +++
 rtl/traffic_phase_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/tlc_pkg.sv
// ============================================================================
// Module   : tlc_pkg
// Brief    : Shared state codes, lamp bit offsets and BCD helper for the
//            traffic phase controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package tlc_pkg;

    typedef enum logic [1:0] {
        ST_GREEN  = 2'd0,
        ST_YELLOW = 2'd1,
        ST_ALLRED = 2'd2,
        ST_FLASH  = 2'd3
    } tlc_state_e;

    localparam int LAMP_G  = 0;
    localparam int LAMP_Y  = 1;
    localparam int LAMP_R  = 2;
    localparam int MAX_SEC = 99;

    // Two-digit display cannot show more than 99; saturate rather than wrap.
    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        logic [6:0] c;
        c = (v > 7'(MAX_SEC)) ? 7'(MAX_SEC) : v;
        return {4'(c / 7'd10), 4'(c % 7'd10)};
    endfunction

endpackage

`default_nettype wire

// File: rtl/tlc_tick_gen.sv
// ============================================================================
// Module   : tlc_tick_gen
// Brief    : Seconds prescaler; one-cycle o_tick every TICK_DIV clocks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tlc_tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic          w_wrap;

    assign w_wrap = (r_cnt == CW'(TICK_DIV - 1));
    assign o_tick = w_wrap;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/traffic_phase_ctrl.sv
// ============================================================================
// Module   : traffic_phase_ctrl
// Brief    : Multi-phase traffic-light sequencer with pedestrian truncation,
//            manual step mode and optional night flash (NIGHT_FLASH_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module traffic_phase_ctrl
    import tlc_pkg::*;
#(
    parameter int TICK_DIV    = 50_000_000,
    parameter int NUM_PHASES  = 2,
    parameter int GREEN_SEC   = 30,
    parameter int YELLOW_SEC  = 3,
    parameter int ALLRED_SEC  = 1,
    parameter int PED_CUT_SEC = 5
) (
    input  logic                    Sys_CLK,
    input  logic                    Sys_RST,
    input  logic                    key_adv,
    input  logic                    manual,
    input  logic                    ped_req,
    input  logic                    night,
    output logic [3*NUM_PHASES-1:0] lamp,
    output logic [7:0]              count_bcd,
    output logic [2:0]              phase,
    output logic [1:0]              state
);

    localparam logic [6:0] c_GREEN  = 7'(GREEN_SEC);
    localparam logic [6:0] c_YELLOW = 7'(YELLOW_SEC);
    localparam logic [6:0] c_ALLRED = 7'(ALLRED_SEC);
    localparam logic [6:0] c_PED    = 7'(PED_CUT_SEC);
    localparam logic [2:0] c_LAST   = 3'(NUM_PHASES - 1);

    tlc_state_e r_state, w_state_nxt, w_seq_state;
    logic [2:0] r_phase, w_phase_nxt, w_seq_phase;
    logic [6:0] r_remain, w_remain_nxt, w_seq_remain;
    logic       w_tick;
    logic       w_flash_on;

    tlc_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .i_clk  (Sys_CLK),
        .i_rst  (Sys_RST),
        .o_tick (w_tick)
    );

    // Successor of the current state in the normal cycle; FLASH exits into
    // the last phase's all-red so the cycle restarts cleanly at phase 0.
    always_comb begin
        w_seq_state  = r_state;
        w_seq_phase  = r_phase;
        w_seq_remain = r_remain;
        case (r_state)
            ST_GREEN: begin
                w_seq_state  = ST_YELLOW;
                w_seq_remain = c_YELLOW;
            end
            ST_YELLOW: begin
                w_seq_state  = ST_ALLRED;
                w_seq_remain = c_ALLRED;
            end
            ST_ALLRED: begin
                w_seq_state  = ST_GREEN;
                w_seq_phase  = (r_phase == c_LAST) ? 3'd0 : r_phase + 3'd1;
                w_seq_remain = c_GREEN;
            end
            default: begin
                w_seq_state  = ST_ALLRED;
                w_seq_phase  = c_LAST;
                w_seq_remain = c_ALLRED;
            end
        endcase
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_phase_nxt  = r_phase;
        w_remain_nxt = r_remain;

        if (manual && key_adv) begin
            w_state_nxt  = w_seq_state;
            w_phase_nxt  = w_seq_phase;
            w_remain_nxt = w_seq_remain;
        end else if (ped_req && (r_state == ST_GREEN) && (r_remain > c_PED)) begin
            w_remain_nxt = c_PED;
        end else if (w_tick && !manual) begin
            if (r_remain == 7'd1) begin
                w_state_nxt  = w_seq_state;
                w_phase_nxt  = w_seq_phase;
                w_remain_nxt = w_seq_remain;
            end else begin
                w_remain_nxt = r_remain - 7'd1;
            end
        end

`ifdef NIGHT_FLASH_EN
        // Night overrides every other request, so it is resolved last.
        if (night) begin
            w_state_nxt  = ST_FLASH;
            w_phase_nxt  = r_phase;
            w_remain_nxt = r_remain;
        end else if (r_state == ST_FLASH) begin
            w_state_nxt  = w_seq_state;
            w_phase_nxt  = w_seq_phase;
            w_remain_nxt = w_seq_remain;
        end
`endif
    end

    always_ff @(posedge Sys_CLK) begin
        if (Sys_RST) begin
            r_state  <= ST_GREEN;
            r_phase  <= 3'd0;
            r_remain <= c_GREEN;
        end else begin
            r_state  <= w_state_nxt;
            r_phase  <= w_phase_nxt;
            r_remain <= w_remain_nxt;
        end
    end

`ifdef NIGHT_FLASH_EN
    logic r_toggle;

    always_ff @(posedge Sys_CLK) begin
        if (Sys_RST) begin
            r_toggle <= 1'b0;
        end else if (r_state == ST_FLASH) begin
            if (w_tick) begin
                r_toggle <= ~r_toggle;
            end
        end else begin
            r_toggle <= 1'b0;
        end
    end

    assign w_flash_on = r_toggle;
`else
    logic w_unused_night;
    assign w_unused_night = night;
    assign w_flash_on     = 1'b0;
`endif

    for (genvar p = 0; p < NUM_PHASES; p++) begin : g_lamp
        logic w_active;
        logic [2:0] w_pl;

        assign w_active = (r_phase == 3'(p));
        assign w_pl = (r_state == ST_FLASH)                ? (w_flash_on ? 3'(1 << LAMP_Y) : 3'b000) :
                      (w_active && r_state == ST_GREEN)    ? 3'(1 << LAMP_G) :
                      (w_active && r_state == ST_YELLOW)   ? 3'(1 << LAMP_Y) :
                                                             3'(1 << LAMP_R);
        assign lamp[3*p +: 3] = w_pl;
    end

    assign count_bcd = (r_state == ST_FLASH) ? 8'h00 : to_bcd(r_remain);
    assign phase     = r_phase;
    assign state     = r_state;

endmodule

`default_nettype wire
